jtag_tap_responder: RTL and testbench
=====================================

# jtag_tap_responder

Device-side IEEE 1149.1 TAP responder: the target end of the JTAG bit-bang/shift stream produced by the blaster handler. It oversamples TCK/TMS/TDI in the CLK domain, runs the 16-state TAP controller and implements IR, BYPASS, IDCODE and one USER data register with parallel capture/update ports. It serves as an on-FPGA loopback target for handler bring-up and as a user debug scan chain.

## Interface
- IR_LEN, 4, instruction register width (≥2)
- USER_LEN, 16, USER data register width (≥1)
- IDCODE_VAL, 32'h031820DD, value captured by IDCODE (bit 0 must be 1)
- IR_IDCODE, 4'h6, IDCODE opcode
- IR_USER, 4'hC, USER opcode; all-ones and every other unlisted code select BYPASS
- CLK  in  1  system clock; reset nRST, asynchronous, active-low; clock CLK
- nRST  in  1  asynchronous active-low reset
- TCK  in  1  JTAG clock, asynchronous to CLK
- TMS  in  1  JTAG mode select
- TDI  in  1  JTAG data in
- TDO  out  1  JTAG data out
- TDO_OE  out  1  high while in SHIFT_DR or SHIFT_IR
- TAP_STATE  out  4  current TAP state code
- IR_OUT  out  IR_LEN  active instruction
- USER_DIN  in  USER_LEN  loaded in CAPTURE_DR when IR_OUT==IR_USER
- USER_DOUT  out  USER_LEN  loaded in UPDATE_DR when IR_OUT==IR_USER
- USER_UPDATE  out  1  one-CLK pulse on each USER_DOUT load

## Operation
- TCK, TMS, TDI pass through identical 2-FF synchronisers; a third TCK stage provides edge detect. rise = s2&~s3, fall = ~s2&s3. TMS/TDI are taken from the s2 stage in the rise cycle.
- On rise: TAP state advances per 1149.1 using TMS; in SHIFT_IR/SHIFT_DR the selected register shifts right, TDI enters the MSB, and the LSB is shifted out.
- On fall: TDO is registered from the LSB of the selected shift register (IR in the IR path, otherwise the DR chosen by IR_OUT). TDO_OE is updated from the current state on the same edge.
- CAPTURE_IR: IR shift register loads {0…0,2'b01}. UPDATE_IR: IR_OUT takes the shift register value.
- CAPTURE_DR: BYPASS loads 0, IDCODE loads IDCODE_VAL, USER loads USER_DIN.
- UPDATE_DR with USER selected: USER_DOUT takes the shift register value and USER_UPDATE pulses.
- TEST_LOGIC_RESET state: IR_OUT is forced to IR_IDCODE. Five consecutive rises with TMS=1 reach TLR from any state.
- State codes (1149.1): TLR F, RTI C, SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PAU_DR 3, EX2_DR 0, UPD_DR 5, SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PAU_IR B, EX2_IR 8, UPD_IR D.

## Timing
- Reset values:
  - TAP_STATE=F, IR_OUT=IR_IDCODE
  - TDO=0, TDO_OE=0
  - USER_DOUT=0, USER_UPDATE=0
  - synchronisers cleared to 0, so a TCK high at reset release produces no rise
- TCK high and low phases must each last ≥2 CLK. TMS/TDI setup ≥1 CLK before TCK rise and hold ≥1 CLK after.
- Latency from a TCK pin edge to its effect is 3 CLK, covering both the state/shift change and the TDO update.
- TDO is valid 3 CLK after TCK falls. The host must sample TDO no earlier than that; bench TCK phases are ≥4 CLK.
- USER_UPDATE is high exactly 1 CLK, 3 CLK after the TCK rise that enters UPDATE_DR. USER_DIN is sampled in the rise cycle that enters CAPTURE_DR.
- nRST mid-shift aborts immediately: state goes to TLR and the partial shift content is discarded. USER_DOUT keeps its reset value of 0.
- Rise and fall are never detected in the same CLK. Glitches shorter than 2 CLK are not supported.

## Structure
- jtag_tap_pkg holds:
  - tap_state_t enum with the codes above
  - function tap_next(state, tms)
  - BYPASS opcode helper
- Sub-module jtag_pin_sync handles the 3-bit synchroniser and TCK edge detect, with outputs tck_rise, tck_fall, tms_s, tdi_s.
- The top level holds the TAP FSM, the shift registers and the DR mux.

## Test plan
- Reset, then TMS 0,1,0,0 to reach SHIFT_DR, then 32 TCK with TDI=0 → TDO reads IDCODE_VAL LSB first, 0x031820DD. TDO_OE=1 during the shift.
- From SHIFT_DR, 5 TCK with TMS=1 → TAP_STATE=F and IR_OUT=6. Repeat the check from PAUSE_IR.
- IR scan of 4'hC → first 4 TDO bits are 1,0,0,0 (the 01 capture). After UPDATE_IR, IR_OUT=C.
- Load IR=F (BYPASS), then shift TDI 1,0,1,1 in SHIFT_DR → TDO is 0,1,0,1, one-bit delayed.
- With IR=USER and USER_DIN=16'hA5C3:
  - a 16-bit DR scan of 16'h1234 shifts out A5C3
  - UPDATE_DR then gives USER_DOUT=16'h1234 and a single USER_UPDATE pulse
- nRST asserted after 7 bits of a USER DR shift → TAP_STATE=F, TDO_OE=0, USER_DOUT stays 0, no USER_UPDATE pulse.

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// Shared TAP types: 1149.1 state encoding, next-state function and
// data-register selection used by the TAP responder.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_t;

  typedef enum logic [1:0] {DR_BYP, DR_ID, DR_USR} dr_sel_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      default: return tms ? SEL_DR : RTI;
    endcase
  endfunction

  // Any opcode that is neither IDCODE nor USER (including all-ones) is BYPASS.
  function automatic dr_sel_t dr_select(input logic is_idcode, input logic is_user);
    if (is_idcode) return DR_ID;
    if (is_user)   return DR_USR;
    return DR_BYP;
  endfunction

  function automatic logic is_ir_path(input tap_state_t s);
    return s inside {CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR};
  endfunction

endpackage

// File: rtl/jtag_tap_responder_pin_sync.sv
// Two-stage synchronisers for TCK/TMS/TDI plus a third TCK stage for
// edge detection in the CLK domain.
module jtag_pin_sync (
  input  logic CLK,
  input  logic nRST,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);
  logic [2:0] s1_q, s1_d, s2_q, s2_d;
  logic       s3_q, s3_d;

  always_comb begin
    s1_d = {tdi, tms, tck};
    s2_d = s1_q;
    s3_d = s2_q[0];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign tck_rise = s2_q[0] & ~s3_q;
  assign tck_fall = ~s2_q[0] & s3_q;
  assign tms_s    = s2_q[1];
  assign tdi_s    = s2_q[2];
endmodule

// File: rtl/jtag_tap_responder.sv
// Device-side TAP: oversampled JTAG pins drive the 16-state controller,
// IR, BYPASS, IDCODE and a USER data register with parallel ports.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int                IR_LEN     = 4,
  parameter int                USER_LEN   = 16,
  parameter logic [31:0]       IDCODE_VAL = 32'h031820DD,
  parameter logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(4'h6),
  parameter logic [IR_LEN-1:0] IR_USER    = IR_LEN'(4'hC)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                TCK,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_OE,
  output logic [3:0]          TAP_STATE,
  output logic [IR_LEN-1:0]   IR_OUT,
  input  logic [USER_LEN-1:0] USER_DIN,
  output logic [USER_LEN-1:0] USER_DOUT,
  output logic                USER_UPDATE
);
  logic tck_rise, tck_fall, tms_s, tdi_s;

  jtag_pin_sync u_sync (
    .CLK(CLK), .nRST(nRST), .tck(TCK), .tms(TMS), .tdi(TDI),
    .tck_rise(tck_rise), .tck_fall(tck_fall), .tms_s(tms_s), .tdi_s(tdi_s)
  );

  tap_state_t          state_q, state_d;
  logic [IR_LEN-1:0]   ir_sr_q, ir_sr_d, ir_out_q, ir_out_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic [USER_LEN-1:0] user_sr_q, user_sr_d, user_dout_q, user_dout_d;
  logic                user_upd_q, user_upd_d, tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  dr_sel_t             dr_sel;

  assign dr_sel = dr_select(ir_out_q == IR_IDCODE, ir_out_q == IR_USER);

  always_comb begin
    state_d     = state_q;
    ir_sr_d     = ir_sr_q;
    ir_out_d    = ir_out_q;
    bypass_d    = bypass_q;
    id_sr_d     = id_sr_q;
    user_sr_d   = user_sr_q;
    user_dout_d = user_dout_q;
    user_upd_d  = 1'b0;
    tdo_d       = tdo_q;
    tdo_oe_d    = tdo_oe_q;

    if (tck_rise) begin
      state_d = tap_next(state_q, tms_s);
      // Shifting belongs to the state being left; capture/update to the one entered.
      if (state_q == SH_IR) begin
        ir_sr_d = ir_sr_q >> 1;
        ir_sr_d[IR_LEN-1] = tdi_s;
      end
      if (state_q == SH_DR) begin
        case (dr_sel)
          DR_ID:   id_sr_d = {tdi_s, id_sr_q[31:1]};
          DR_USR:  begin
            user_sr_d = user_sr_q >> 1;
            user_sr_d[USER_LEN-1] = tdi_s;
          end
          default: bypass_d = tdi_s;
        endcase
      end
      case (state_d)
        TLR:     ir_out_d = IR_IDCODE;
        CAP_IR:  begin
          ir_sr_d    = '0;
          ir_sr_d[0] = 1'b1;
        end
        UPD_IR:  ir_out_d = ir_sr_q;
        CAP_DR:  begin
          bypass_d  = 1'b0;
          id_sr_d   = IDCODE_VAL;
          user_sr_d = USER_DIN;
        end
        UPD_DR:  if (dr_sel == DR_USR) begin
          user_dout_d = user_sr_q;
          user_upd_d  = 1'b1;
        end
        default: ;
      endcase
    end

    if (tck_fall) begin
      tdo_oe_d = (state_q == SH_DR) || (state_q == SH_IR);
      if (is_ir_path(state_q)) tdo_d = ir_sr_q[0];
      else begin
        case (dr_sel)
          DR_ID:   tdo_d = id_sr_q[0];
          DR_USR:  tdo_d = user_sr_q[0];
          default: tdo_d = bypass_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= TLR;
      ir_sr_q     <= '0;
      ir_out_q    <= IR_IDCODE;
      bypass_q    <= 1'b0;
      id_sr_q     <= '0;
      user_sr_q   <= '0;
      user_dout_q <= '0;
      user_upd_q  <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_sr_q     <= ir_sr_d;
      ir_out_q    <= ir_out_d;
      bypass_q    <= bypass_d;
      id_sr_q     <= id_sr_d;
      user_sr_q   <= user_sr_d;
      user_dout_q <= user_dout_d;
      user_upd_q  <= user_upd_d;
      tdo_q       <= tdo_d;
      tdo_oe_q    <= tdo_oe_d;
    end
  end

  assign TDO         = tdo_q;
  assign TDO_OE      = tdo_oe_q;
  assign TAP_STATE   = state_q;
  assign IR_OUT      = ir_out_q;
  assign USER_DOUT   = user_dout_q;
  assign USER_UPDATE = user_upd_q;
endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench: drives the TAP pins like a host and checks against
// hand-computed values.
module tb_jtag_tap_responder;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        TCK = 1'b0, TMS = 1'b0, TDI = 1'b0;
  logic        TDO, TDO_OE, USER_UPDATE;
  logic [3:0]  TAP_STATE, IR_OUT;
  logic [15:0] USER_DIN = 16'h0, USER_DOUT;
  int          n_chk = 0, n_fail = 0, upd_cnt = 0;

  jtag_tap_responder dut (
    .CLK(CLK), .nRST(nRST), .TCK(TCK), .TMS(TMS), .TDI(TDI),
    .TDO(TDO), .TDO_OE(TDO_OE), .TAP_STATE(TAP_STATE), .IR_OUT(IR_OUT),
    .USER_DIN(USER_DIN), .USER_DOUT(USER_DOUT), .USER_UPDATE(USER_UPDATE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (USER_UPDATE) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One TCK period; returns TDO as sampled just before the rising edge.
  task automatic jtag_step(input logic tms_v, input logic tdi_v, output logic tdo_v);
    @(negedge CLK);
    TMS = tms_v; TDI = tdi_v;
    wait_clk(2);
    tdo_v = TDO;
    TCK = 1'b1; wait_clk(4);
    TCK = 1'b0; wait_clk(4);
  endtask

  task automatic tms_step(input logic v);
    logic o;
    jtag_step(v, 1'b0, o);
  endtask

  // Starts in RTI/UPD_*, ends in RTI.
  task automatic scan_ir(input logic [3:0] val, output logic [3:0] out);
    logic o;
    tms_step(1); tms_step(1); tms_step(0); tms_step(0);
    for (int i = 0; i < 4; i++) begin
      jtag_step(i == 3, val[i], o);
      out[i] = o;
    end
    tms_step(1); tms_step(0);
  endtask

  task automatic scan_dr(input logic [31:0] val, input int n, output logic [31:0] out);
    logic o;
    out = '0;
    tms_step(1); tms_step(0); tms_step(0);
    for (int i = 0; i < n; i++) begin
      jtag_step(i == n - 1, val[i], o);
      out[i] = o;
    end
    tms_step(1); tms_step(0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  ro;
    logic        o;
    int          c0;
    wait_clk(3);
    nRST = 1'b1;
    wait_clk(4);
    chk("rst_state", TAP_STATE, 4'hF);
    chk("rst_ir", IR_OUT, 4'h6);
    chk("rst_tdo", TDO, 0);
    chk("rst_oe", TDO_OE, 0);
    chk("rst_dout", USER_DOUT, 0);
    chk("rst_upd", USER_UPDATE, 0);

    // IDCODE read straight out of reset
    tms_step(0); tms_step(1); tms_step(0); tms_step(0);
    chk("shdr_state", TAP_STATE, 4'h2);
    chk("shdr_oe", TDO_OE, 1);
    for (int i = 0; i < 32; i++) begin
      jtag_step(1'b0, 1'b0, o);
      rd[i] = o;
    end
    chk("idcode", rd, 32'h031820DD);
    chk("idcode_oe", TDO_OE, 1);

    repeat (5) tms_step(1);
    chk("tlr_from_shdr", TAP_STATE, 4'hF);
    chk("tlr_ir", IR_OUT, 4'h6);
    tms_step(0);
    chk("rti_oe", TDO_OE, 0);

    scan_ir(4'hC, ro);
    chk("ir_capture", ro, 4'b0001);
    chk("ir_user", IR_OUT, 4'hC);
    chk("rti_state", TAP_STATE, 4'hC);

    USER_DIN = 16'hA5C3;
    c0 = upd_cnt;
    scan_dr(32'h1234, 16, rd);
    chk("user_out", rd, 32'hA5C3);
    chk("user_dout", USER_DOUT, 16'h1234);
    chk("user_pulses", upd_cnt - c0, 1);

    // Reach PAUSE_IR, then escape with TMS=1
    tms_step(1); tms_step(1); tms_step(0); tms_step(0); tms_step(1); tms_step(0);
    chk("pause_ir", TAP_STATE, 4'hB);
    chk("pause_ir_keep", IR_OUT, 4'hC);
    repeat (5) tms_step(1);
    chk("tlr_from_pauir", TAP_STATE, 4'hF);
    chk("tlr_ir2", IR_OUT, 4'h6);
    tms_step(0);

    scan_ir(4'hF, ro);
    chk("ir_bypass", IR_OUT, 4'hF);
    c0 = upd_cnt;
    tms_step(1); tms_step(0); tms_step(0);
    jtag_step(0, 1, o); ro[0] = o;
    jtag_step(0, 0, o); ro[1] = o;
    jtag_step(0, 1, o); ro[2] = o;
    jtag_step(0, 1, o); ro[3] = o;
    chk("bypass_out", ro, 4'b1010);
    tms_step(1); tms_step(1); tms_step(0);
    chk("bypass_no_upd", upd_cnt - c0, 0);
    chk("bypass_dout", USER_DOUT, 16'h1234);
    chk("bypass_oe", TDO_OE, 0);

    // Reset in the middle of a USER shift
    scan_ir(4'hC, ro);
    c0 = upd_cnt;
    tms_step(1); tms_step(0); tms_step(0);
    for (int i = 0; i < 7; i++) jtag_step(1'b0, i[0], o);
    @(negedge CLK);
    nRST = 1'b0;
    wait_clk(1);
    chk("abort_state", TAP_STATE, 4'hF);
    chk("abort_oe", TDO_OE, 0);
    chk("abort_dout", USER_DOUT, 0);
    chk("abort_ir", IR_OUT, 4'h6);
    nRST = 1'b1;
    wait_clk(10);
    chk("abort_no_upd", upd_cnt - c0, 0);
    chk("abort_state2", TAP_STATE, 4'hF);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
